game_mmio_regs: RTL
===================

Name: game_mmio_regs

Overview:
- Avalon-MM slave register bank hanging directly off the HPS-side memory-mapped output conduit (5-bit word address, 32-bit data, byteenable, fixed read latency 1, no waitrequest).
- Gives software a game control plane: ID, control, status, a tick prescaler with interrupt, button capture, a score register, and a command FIFO.
- The command FIFO drains by valid/ready into the downstream game engine.

Parameters:
- FIFO_DEPTH, 16, command FIFO entries; power of 2, 2..16.
- DEBOUNCE_CYCLES, 50000, stable cycles required before a button level is accepted (only used with the optional feature).
- ID_VALUE, 32'h47414D45, constant returned by the ID register.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- mmo_reset  in  1  synchronous active-high soft reset from the bridge; same effect as reset
- mmo_address  in  5  word address
- mmo_writedata  in  32  write data
- mmo_byteenable  in  4  byte lanes
- mmo_read  in  1  read strobe
- mmo_write  in  1  write strobe
- mmo_readdata  out  32  read data, registered, valid the cycle after mmo_read
- btn_i  in  5  raw asynchronous push-buttons, active high
- cmd_valid_o  out  1  FIFO head valid
- cmd_data_o  out  32  FIFO head; forced to 0 when empty
- cmd_ready_i  in  1  consumer accepts head
- score_o  out  32  SCORE register to the display
- irq_o  out  1  level interrupt

Behaviour:
- Reset (either source): all outputs 0, all registers 0, FIFO empty, TICK_DIV = 0, button synchronisers 0.
- Register map (word address):
  - 0x00 ID: RO ID_VALUE.
  - 0x01 CTRL: RW; bit0 RUN, bit1 IRQ_EN, bit2 FLUSH (write-1 self-clears, reads 0).
  - 0x02 STATUS: bit0 TICK_PEND (W1C), [8:4] FIFO count, bit9 FULL, bit10 EMPTY, bit11 OVF (W1C); all other bits read 0.
  - 0x03 TICK_DIV: RW, 32-bit.
  - 0x04 TICK_CNT: RO.
  - 0x05 BTN: [4:0] filtered level (RO), [12:8] press latch (W1C).
  - 0x06 CMD_PUSH: WO, reads 0.
  - 0x07 SCORE: RW.
  - 0x08-0x1F: reads 0, writes ignored.
- Byteenable: RW registers update only the enabled bytes. CMD_PUSH pushes on any write; disabled bytes are stored as 0.
- Read path: mmo_readdata is registered from the pre-update state of the read cycle. It holds its value when mmo_read = 0. Simultaneous read and write to the same address returns the old value.
- Tick prescaler:
  - With RUN = 1: counts down from TICK_DIV. At 0 it emits a 1-cycle tick and reloads, so period = TICK_DIV + 1 cycles. TICK_DIV = 0 gives a tick every cycle.
  - Each tick: TICK_CNT += 1 (wraps at 2^32), TICK_PEND set.
  - RUN = 0: prescaler held at TICK_DIV, TICK_CNT held.
  - RUN 0->1 write: clears TICK_CNT and loads the prescaler.
  - Writing TICK_DIV reloads the prescaler next cycle.
- Flag precedence: in the same cycle, a hardware set beats a W1C clear, for TICK_PEND, OVF and the press latches.
- irq_o = registered (TICK_PEND & IRQ_EN); it lags TICK_PEND by 1 cycle.
- Buttons: 2-FF synchroniser (optionally debounced). A rising edge of the filtered level sets the press latch bit.
- FIFO: show-ahead. cmd_valid_o = !EMPTY. A pop occurs when cmd_valid_o & cmd_ready_i.
  - Push when not full: accepted; visible on cmd_valid_o the next cycle.
  - Push when full with no pop that cycle: dropped, OVF set.
  - Push when full with a pop the same cycle: accepted, count unchanged.
  - Push and pop when empty: push accepted, nothing popped.
  - FLUSH: empties the FIFO next cycle. A push in the same write cycle is dropped without setting OVF; a pop in the same cycle is ignored.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Soft or hard reset mid-transfer: FIFO contents discarded, cmd_valid_o drops in the same cycle (hard reset) or next cycle (soft reset).

Optional Feature:
- Macro: GAME_BTN_DEBOUNCE_EN.
- Defined: each synchronised button has a counter. The filtered level changes only after the input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- Undefined: filtered level = 2-FF synchroniser output (2-cycle latency) and the counters are not built. Register map is unchanged either way.

Test Plan:
- Reset, then read 0x00 -> 0x47414D45 one cycle after mmo_read. Read 0x02 -> 0x00000400 (EMPTY). Read 0x1F -> 0. All outputs 0 during reset.
- Write TICK_DIV = 3, CTRL = 0x3 -> tick every 4 cycles. After 20 cycles TICK_CNT = 5 and irq_o = 1. Write STATUS = 0x1 -> irq_o falls 1 cycle after TICK_PEND clears; if a tick lands on the W1C cycle, TICK_PEND stays 1.
- Push 16 words with cmd_ready_i = 0 -> FULL = 1, count = 16. A 17th push -> OVF = 1, data dropped. Raise cmd_ready_i -> words 1..16 emerge in order, one per cycle, then cmd_valid_o = 0.
- FIFO full, cmd_ready_i = 1 and a push in the same cycle -> push accepted, count stays 16, OVF stays 0. Write CTRL = 0x4 together with a pending push -> FIFO empty, OVF = 0.
- Write SCORE with byteenable = 4'b0010, data 0xAABBCCDD from SCORE = 0 -> score_o = 0x0000CC00. Partial push with byteenable = 4'b0001 -> cmd_data_o = 0x000000DD.
- btn_i[2] bouncing 0/1 for 10 cycles, then held 1 -> with debounce enabled, no change until DEBOUNCE_CYCLES stable cycles; then BTN[2] = 1 and press latch bit10 = 1. Without debounce, BTN[2] follows btn_i after 2 cycles. Writing 0x400 to BTN clears the latch.

Source files
------------

// File: rtl/game_mmio_regs.sv
// game_mmio_regs: Avalon-MM game control register bank with tick prescaler, button capture and command FIFO.
// Optional button debouncing is enabled by defining GAME_BTN_DEBOUNCE_EN.
module game_mmio_regs #(
  parameter int          FIFO_DEPTH      = 16,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] ID_VALUE        = 32'h47414D45
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        mmo_reset,
  input  logic [4:0]  mmo_address,
  input  logic [31:0] mmo_writedata,
  input  logic [3:0]  mmo_byteenable,
  input  logic        mmo_read,
  input  logic        mmo_write,
  output logic [31:0] mmo_readdata,
  input  logic [4:0]  btn_i,
  output logic        cmd_valid_o,
  output logic [31:0] cmd_data_o,
  input  logic        cmd_ready_i,
  output logic [31:0] score_o,
  output logic        irq_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 5;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("game_mmio_regs: FIFO_DEPTH must be 2..16 and DEBOUNCE_CYCLES >= 1");
  end

  logic        run_q, run_d, irq_en_q, irq_en_d;
  logic [31:0] tick_div_q, tick_div_d, presc_q, presc_d, tick_cnt_q, tick_cnt_d;
  logic [31:0] score_q, score_d, rdata_q, rdata_d, rmux;
  logic        pend_q, pend_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [4:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, press_q, press_d;
  logic [4:0]  btn_lvl;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] mem [FIFO_DEPTH];
  logic [31:0] ctrl_new, push_data;
  logic        we_ctrl, we_status, we_div, we_btn, we_push, we_score;
  logic        flush, run_rise, tick, full, empty, pop, push_ok;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  assign we_ctrl   = mmo_write && (mmo_address == 5'h01);
  assign we_status = mmo_write && (mmo_address == 5'h02);
  assign we_div    = mmo_write && (mmo_address == 5'h03);
  assign we_btn    = mmo_write && (mmo_address == 5'h05);
  assign we_push   = mmo_write && (mmo_address == 5'h06);
  assign we_score  = mmo_write && (mmo_address == 5'h07);

  assign ctrl_new  = be_merge({30'b0, irq_en_q, run_q}, mmo_writedata, mmo_byteenable);
  assign flush     = we_ctrl && ctrl_new[2];
  assign run_rise  = we_ctrl && ctrl_new[0] && !run_q;
  assign push_data = be_merge(32'h0, mmo_writedata, mmo_byteenable);

  assign tick    = run_q && (presc_q == 32'd0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && cmd_ready_i;
  assign push_ok = we_push && !flush && (!full || pop);

`ifdef GAME_BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [4:0]    lvl_q;
  logic [DW-1:0] db_cnt_q [5];

  // A level flips only after the synchronised input has disagreed with it for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lvl_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else if (mmo_reset) begin
      lvl_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end
  assign btn_lvl = lvl_q;
`else
  assign btn_lvl = sync2_q;
`endif

  always_comb begin
    rmux = 32'h0;
    case (mmo_address)
      5'h00:   rmux = ID_VALUE;
      5'h01:   rmux = {30'b0, irq_en_q, run_q};
      5'h02:   rmux = {20'b0, ovf_q, empty, full, count_q, 3'b0, pend_q};
      5'h03:   rmux = tick_div_q;
      5'h04:   rmux = tick_cnt_q;
      5'h05:   rmux = {19'b0, press_q, 3'b0, btn_lvl};
      5'h07:   rmux = score_q;
      default: rmux = 32'h0;
    endcase
  end

  // Next state for every register; the soft reset overrides everything at the end.
  always_comb begin
    rdata_d    = mmo_read ? rmux : rdata_q;
    run_d      = we_ctrl ? ctrl_new[0] : run_q;
    irq_en_d   = we_ctrl ? ctrl_new[1] : irq_en_q;
    tick_div_d = we_div ? be_merge(tick_div_q, mmo_writedata, mmo_byteenable) : tick_div_q;
    score_d    = we_score ? be_merge(score_q, mmo_writedata, mmo_byteenable) : score_q;

    presc_d = presc_q;
    if (run_q) presc_d = tick ? tick_div_q : presc_q - 32'd1;
    if (!run_q || run_rise || we_div) presc_d = tick_div_d;
    tick_cnt_d = tick ? tick_cnt_q + 32'd1 : tick_cnt_q;
    if (run_rise) tick_cnt_d = 32'd0;

    pend_d = tick || (pend_q && !(we_status && mmo_byteenable[0] && mmo_writedata[0]));
    irq_d  = pend_q && irq_en_q;
    ovf_d  = (we_push && !flush && full && !pop) ||
             (ovf_q && !(we_status && mmo_byteenable[1] && mmo_writedata[11]));

    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = btn_lvl;
    press_d = (btn_lvl & ~prev_q) |
              (press_q & ~((we_btn && mmo_byteenable[1]) ? mmo_writedata[12:8] : 5'b0));

    wr_ptr_d = wr_ptr_q + (push_ok ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : PW'(0));
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    if (mmo_reset) begin
      rdata_d = '0; run_d = 1'b0; irq_en_d = 1'b0; tick_div_d = '0; score_d = '0;
      presc_d = '0; tick_cnt_d = '0; pend_d = 1'b0; irq_d = 1'b0; ovf_d = 1'b0;
      sync1_d = '0; sync2_d = '0; prev_d = '0; press_d = '0;
      wr_ptr_d = '0; rd_ptr_d = '0; count_d = '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rdata_q <= '0; run_q <= 1'b0; irq_en_q <= 1'b0; tick_div_q <= '0; score_q <= '0;
      presc_q <= '0; tick_cnt_q <= '0; pend_q <= 1'b0; irq_q <= 1'b0; ovf_q <= 1'b0;
      sync1_q <= '0; sync2_q <= '0; prev_q <= '0; press_q <= '0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
    end else begin
      rdata_q <= rdata_d; run_q <= run_d; irq_en_q <= irq_en_d; tick_div_q <= tick_div_d;
      score_q <= score_d; presc_q <= presc_d; tick_cnt_q <= tick_cnt_d; pend_q <= pend_d;
      irq_q <= irq_d; ovf_q <= ovf_d; sync1_q <= sync1_d; sync2_q <= sync2_d;
      prev_q <= prev_d; press_q <= press_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk_clk) begin
    if (push_ok && !mmo_reset) mem[wr_ptr_q] <= push_data;
  end

  assign mmo_readdata = rdata_q;
  assign cmd_valid_o  = !empty;
  assign cmd_data_o   = empty ? 32'h0 : mem[rd_ptr_q];
  assign score_o      = score_q;
  assign irq_o        = irq_q;
endmodule
